// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch and execute stages: opcodes, instruction field
// positions and the fetch-stage state type.
package fetch_pkg;

  localparam int OPER_MSB  = 31;
  localparam int OPER_LSB  = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int IMM_BIT   = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int ISRC_MSB  = 15;
  localparam int ISRC_LSB  = 0;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {instruction, pc} between the instruction memory and the execute stage.
// Head is driven straight from registers so the consumer sees no path from the memory.
module fetch_buf #(
  parameter int                DATA_W = 32,
  parameter int                ADDR_W = 8,
  parameter logic [ADDR_W-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_instr,
  output logic [ADDR_W-1:0] head_pc,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] instr_q [2];
  logic [ADDR_W-1:0] pc_q    [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // NOTE: the storage is reset too, because the head is visible on the outputs and
  // must read as instruction 0 at the reset pc straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '{default: '0};
      pc_q     <= '{default: PC_RST};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= push_instr;
        pc_q[wr_ptr_q]    <= push_pc;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, read issue to a 1-cycle synchronous instruction memory,
// redirect/halt control, and a 2-entry buffer presenting words to the execute stage.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic [1:0]        count;
  logic [2:0]        load;
  logic              xfer;
  logic              halt_xfer;
  logic              push;
  logic              flush;

  assign ir_valid  = (count != 2'd0);
  assign xfer      = ir_valid & ir_ready;
  assign halt_xfer = xfer && (ir_out[OPER_MSB:OPER_LSB] == HALT_OP);
  // Occupancy counts the head as gone when it transfers this cycle; that is what lets
  // the stage sustain one word per cycle without ever overfilling the buffer.
  assign load      = {1'b0, count} - {2'b0, xfer} + {2'b0, inflight_q};
  assign imem_addr = pc_q;
  assign halted    = (state_q == ST_HALTED);

  // NOTE: every output of this block is given a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    imem_en = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_en = !rst && !redirect_en && !halt_xfer && (load < 3'd2);
        push    = inflight_q && !redirect_en && !halt_xfer;
        if (redirect_en) begin
          flush = 1'b1;
        end else if (halt_xfer) begin
          flush   = 1'b1;
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (redirect_en) begin
          flush   = 1'b1;
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      // No read is issued in a flush cycle, so this also squashes any in-flight word.
      inflight_q <= imem_en;
      if (imem_en) inflight_pc_q <= pc_q;
      if (redirect_en)  pc_q <= redirect_pc;
      else if (imem_en) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  fetch_buf #(
    .DATA_W(INSTR_W),
    .ADDR_W(ADDR_W),
    .PC_RST(RESET_PC)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_instr(imem_rdata),
    .push_pc   (inflight_pc_q),
    .pop       (xfer),
    .flush     (flush),
    .head_instr(ir_out),
    .head_pc   (ir_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle tables for start-up and back-pressure,
// directed redirect/wrap/reset/halt sequences, then random traffic against a stream model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halted;

  logic [31:0] mem [256];
  int          n_vec = 0;
  int          n_mis = 0;

  localparam logic [31:0] HALT_WORD = {OP_HALT, 27'b0};

  typedef struct {
    logic        ready;
    logic        en;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
    logic [31:0] out;
  } vec_t;

  vec_t tbl [14];

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ir_out     (ir_out),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rdy, input logic rd, input logic [7:0] rpc);
    @(negedge clk);
    rst         = 1'b0;
    ir_ready    = rdy;
    redirect_en = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".imem_en"},   32'(imem_en),   32'd0);
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, ".ir_valid"},  32'(ir_valid),  32'd0);
    check({tag, ".ir_pc"},     32'(ir_pc),     32'd0);
    check({tag, ".ir_out"},    ir_out,         32'd0);
    check({tag, ".halted"},    32'(halted),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ir_ready = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
    #1;
    check_reset("reset");
    @(negedge clk);
  endtask

  task automatic run_table(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      apply(tbl[i].ready, 1'b0, 8'h00);
      check($sformatf("%s[%0d].imem_en", tag, i),   32'(imem_en),   32'(tbl[i].en));
      check($sformatf("%s[%0d].imem_addr", tag, i), 32'(imem_addr), 32'(tbl[i].addr));
      check($sformatf("%s[%0d].ir_valid", tag, i),  32'(ir_valid),  32'(tbl[i].valid));
      check($sformatf("%s[%0d].ir_pc", tag, i),     32'(ir_pc),     32'(tbl[i].pc));
      check($sformatf("%s[%0d].ir_out", tag, i),    ir_out,         tbl[i].out);
    end
  endtask

  task automatic redirect_seq(input string tag, input logic [7:0] tgt, input logic rdy);
    logic [7:0] nxt;
    nxt = tgt + 8'd1;
    apply(rdy, 1'b1, tgt);
    check({tag, ".en_redirect"}, 32'(imem_en), 32'd0);
    apply(1'b1, 1'b0, 8'h00);
    check({tag, ".gap1_valid"}, 32'(ir_valid),  32'd0);
    check({tag, ".gap1_en"},    32'(imem_en),   32'd1);
    check({tag, ".gap1_addr"},  32'(imem_addr), 32'(tgt));
    apply(1'b1, 1'b0, 8'h00);
    check({tag, ".gap2_valid"}, 32'(ir_valid), 32'd0);
    apply(1'b1, 1'b0, 8'h00);
    check({tag, ".w0_valid"}, 32'(ir_valid), 32'd1);
    check({tag, ".w0_pc"},    32'(ir_pc),    32'(tgt));
    check({tag, ".w0_out"},   ir_out,        mem[tgt]);
    apply(1'b1, 1'b0, 8'h00);
    check({tag, ".w1_pc"},  32'(ir_pc), 32'(nxt));
    check({tag, ".w1_out"}, ir_out,     mem[nxt]);
  endtask

  initial begin
    logic [7:0] exp_pc;
    bit         m_halted;
    int         blank;
    int         gap;
    logic       rdy, rd, xfer, halt_w;
    logic [7:0] rpc;

    for (int k = 0; k < 256; k++) mem[k] = 32'(k + 100);

    // Start-up from reset (steps 0-4), then ir_ready low for five cycles (steps 5-9).
    tbl[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 32'd100};
    tbl[3]  = '{1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 32'd101};
    tbl[4]  = '{1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 32'd102};
    tbl[5]  = '{1'b0, 1'b0, 8'h05, 1'b1, 8'h03, 32'd103};
    tbl[6]  = '{1'b0, 1'b0, 8'h05, 1'b1, 8'h03, 32'd103};
    tbl[7]  = '{1'b0, 1'b0, 8'h05, 1'b1, 8'h03, 32'd103};
    tbl[8]  = '{1'b0, 1'b0, 8'h05, 1'b1, 8'h03, 32'd103};
    tbl[9]  = '{1'b0, 1'b0, 8'h05, 1'b1, 8'h03, 32'd103};
    tbl[10] = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h03, 32'd103};
    tbl[11] = '{1'b1, 1'b1, 8'h06, 1'b1, 8'h04, 32'd104};
    tbl[12] = '{1'b1, 1'b1, 8'h07, 1'b1, 8'h05, 32'd105};
    tbl[13] = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h06, 32'd106};

    do_reset();
    run_table("start", 14);

    redirect_seq("redir40", 8'h40, 1'b1);

    // Fill the buffer under back-pressure, then redirect with it full.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 8'h00);
      check("bp_hold.ir_pc", 32'(ir_pc), 32'h42);
    end
    redirect_seq("redir80", 8'h80, 1'b0);

    redirect_seq("wrap", 8'hFE, 1'b1);
    apply(1'b1, 1'b0, 8'h00);
    check("wrap.ir_pc", 32'(ir_pc), 32'h00);
    check("wrap.ir_out", ir_out, mem[0]);

    // Asynchronous reset in the middle of a running stream.
    check("midrst.pre_valid", 32'(ir_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    run_table("restart", 5);

    // HALT at word 3, then leave the halted state with a redirect.
    mem[3] = HALT_WORD;
    do_reset();
    run_table("halt_pre", 5);
    apply(1'b1, 1'b0, 8'h00);
    check("halt.w3_pc",  32'(ir_pc),  32'h03);
    check("halt.w3_out", ir_out,      HALT_WORD);
    check("halt.w3_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 8'h00);
      check("halt.halted",   32'(halted),   32'd1);
      check("halt.ir_valid", 32'(ir_valid), 32'd0);
      check("halt.imem_en",  32'(imem_en),  32'd0);
    end
    apply(1'b1, 1'b1, 8'h10);
    check("halt.redir_halted", 32'(halted),  32'd1);
    check("halt.redir_en",     32'(imem_en), 32'd0);
    apply(1'b1, 1'b0, 8'h00);
    check("halt.resume_halted", 32'(halted),    32'd0);
    check("halt.resume_addr",   32'(imem_addr), 32'h10);
    check("halt.resume_valid",  32'(ir_valid),  32'd0);
    apply(1'b1, 1'b0, 8'h00);
    check("halt.resume_gap", 32'(ir_valid), 32'd0);
    apply(1'b1, 1'b0, 8'h00);
    check("halt.resume_pc",  32'(ir_pc), 32'h10);
    check("halt.resume_out", ir_out,     mem[8'h10]);

    // Random traffic. Model: the transferred stream is mem[p], mem[p+1], ... from the
    // last reset or redirect target; it stops after a HALT word until the next redirect.
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom;
      if ($urandom_range(15) == 0) mem[k][31:27] = OP_HALT;
    end
    do_reset();
    exp_pc = 8'h00; m_halted = 1'b0; blank = 0; gap = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(3) != 0);
      rd  = ($urandom_range(31) == 0);
      rpc = 8'($urandom);
      apply(rdy, rd, rpc);
      check("rnd.halted", 32'(halted), 32'(m_halted));
      if (m_halted) begin
        check("rnd.halted_valid", 32'(ir_valid), 32'd0);
        check("rnd.halted_en",    32'(imem_en),  32'd0);
      end
      if (blank > 0) begin
        check("rnd.redirect_gap", 32'(ir_valid), 32'd0);
        blank--;
      end
      if (rd) check("rnd.en_redirect", 32'(imem_en), 32'd0);
      if (ir_valid) begin
        check("rnd.ir_pc",  32'(ir_pc), 32'(exp_pc));
        check("rnd.ir_out", ir_out,      mem[exp_pc]);
        gap = 0;
      end else if (!m_halted) begin
        gap++;
        check("rnd.starved", 32'(gap > 2), 32'd0);
      end
      xfer   = ir_valid && rdy;
      halt_w = 1'b0;
      if (xfer) begin
        halt_w = (mem[exp_pc][31:27] == OP_HALT);
        exp_pc = exp_pc + 8'd1;
      end
      if (rd) begin
        exp_pc = rpc; m_halted = 1'b0; blank = 2; gap = 0;
      end else if (xfer && halt_w) begin
        m_halted = 1'b1; gap = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
